// File: rtl/hazard_sequencer.sv
// Hazard controller for a 5-stage LEGv8 pipeline: operand forwarding, load-use
// stalls, taken-branch IF/ID flush and the architectural NZCV flag register.
module hazard_sequencer #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_read_en,
    input  logic             id_flagset,
    input  logic             id_was_branch,
    input  logic             id_br_taken,
    input  logic             id_is_blt,
    input  logic [3:0]       ex_flags,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [3:0]       flags_out,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ex_bubble,
    output logic             flush_ifid,
    output logic [15:0]      stall_count
);

    localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

    // Shadow copy of the in-flight instructions; MEM/WB only need what forwarding reads.
    logic             ex_valid_q, ex_rw_q, ex_load_q, ex_flagset_q;
    logic [REG_W-1:0] ex_rd_q;
    logic             mem_valid_q, mem_rw_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             wb_valid_q, wb_rw_q;
    logic [REG_W-1:0] wb_rd_q;
    logic [3:0]       flags_q;
    logic             flush_ifid_q;
    logic [15:0]      stall_count_q;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic stall, flush_d, ex_valid_d;

    function automatic logic hit(input logic v, input logic rw, input logic [REG_W-1:0] rd,
                                 input logic [REG_W-1:0] r, input logic uses);
        return v & rw & (rd == r) & (r != ZERO_IDX) & uses;
    endfunction

    always_comb begin
        ex_hit_a  = hit(ex_valid_q,  ex_rw_q,  ex_rd_q,  id_rn, id_uses_rn);
        ex_hit_b  = hit(ex_valid_q,  ex_rw_q,  ex_rd_q,  id_rm, id_uses_rm);
        mem_hit_a = hit(mem_valid_q, mem_rw_q, mem_rd_q, id_rn, id_uses_rn);
        mem_hit_b = hit(mem_valid_q, mem_rw_q, mem_rd_q, id_rm, id_uses_rm);
        wb_hit_a  = hit(wb_valid_q,  wb_rw_q,  wb_rd_q,  id_rn, id_uses_rn);
        wb_hit_b  = hit(wb_valid_q,  wb_rw_q,  wb_rd_q,  id_rm, id_uses_rm);

        stall      = id_valid & ex_valid_q & ex_load_q & (ex_hit_a | ex_hit_b);
        flush_d    = id_valid & id_was_branch & id_br_taken & ~stall;
        ex_valid_d = id_valid & ~stall & ~flush_ifid_q;

        // Nearest producer wins; a load in EX cannot forward yet, the stall covers it.
        fwd_a = 2'b00;
        if (ex_hit_a && !ex_load_q) fwd_a = 2'b01;
        else if (mem_hit_a)         fwd_a = 2'b10;
        else if (wb_hit_a)          fwd_a = 2'b11;

        fwd_b = 2'b00;
        if (ex_hit_b && !ex_load_q) fwd_b = 2'b01;
        else if (mem_hit_b)         fwd_b = 2'b10;
        else if (wb_hit_b)          fwd_b = 2'b11;

        flags_out = (id_is_blt && ex_valid_q && ex_flagset_q) ? ex_flags : flags_q;
    end

    assign pc_en       = ~stall;
    assign ifid_en     = ~stall;
    assign ex_bubble   = stall;
    assign flush_ifid  = flush_ifid_q;
    assign stall_count = stall_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q    <= 1'b0;
            ex_rw_q       <= 1'b0;
            ex_load_q     <= 1'b0;
            ex_flagset_q  <= 1'b0;
            ex_rd_q       <= '0;
            mem_valid_q   <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_rd_q      <= '0;
            wb_valid_q    <= 1'b0;
            wb_rw_q       <= 1'b0;
            wb_rd_q       <= '0;
            flags_q       <= 4'b0000;
            flush_ifid_q  <= 1'b0;
            stall_count_q <= 16'h0000;
        end else begin
            wb_valid_q   <= mem_valid_q;
            wb_rw_q      <= mem_rw_q;
            wb_rd_q      <= mem_rd_q;
            mem_valid_q  <= ex_valid_q;
            mem_rw_q     <= ex_rw_q;
            mem_rd_q     <= ex_rd_q;
            ex_valid_q   <= ex_valid_d;
            ex_rw_q      <= id_regwrite;
            ex_load_q    <= id_read_en;
            ex_flagset_q <= id_flagset;
            ex_rd_q      <= id_rd;
            if (ex_valid_q && ex_flagset_q) flags_q <= ex_flags;
            flush_ifid_q <= flush_d;
            if (stall && stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'h0001;
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: inputs change 1ns after the rising edge,
// outputs are checked on the falling edge.
module tb_hazard_sequencer;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        id_uses_rn, id_uses_rm, id_regwrite, id_read_en, id_flagset;
    logic        id_was_branch, id_br_taken, id_is_blt;
    logic [3:0]  ex_flags;
    logic [1:0]  fwd_a, fwd_b;
    logic [3:0]  flags_out;
    logic        pc_en, ifid_en, ex_bubble, flush_ifid;
    logic [15:0] stall_count;

    int checks   = 0;
    int failures = 0;

    hazard_sequencer #(.REG_W(5), .ZERO_REG(31)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_uses_rn   (id_uses_rn),
        .id_uses_rm   (id_uses_rm),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_read_en   (id_read_en),
        .id_flagset   (id_flagset),
        .id_was_branch(id_was_branch),
        .id_br_taken  (id_br_taken),
        .id_is_blt    (id_is_blt),
        .ex_flags     (ex_flags),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .flags_out    (flags_out),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ex_bubble    (ex_bubble),
        .flush_ifid   (flush_ifid),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // v, rn, uses_rn, rm, uses_rm, rd, regwrite, load, flagset, branch, taken, blt, ex_flags
    task automatic drive(input logic v, input logic [4:0] rn, input logic urn,
                         input logic [4:0] rm, input logic urm, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic fs, input logic br,
                         input logic tk, input logic blt, input logic [3:0] fl);
        id_valid = v;   id_rn = rn;   id_uses_rn = urn; id_rm = rm; id_uses_rm = urm;
        id_rd = rd;     id_regwrite = rw; id_read_en = ld; id_flagset = fs;
        id_was_branch = br; id_br_taken = tk; id_is_blt = blt; ex_flags = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Reset state with an idle ID stage
        idle(); settle();
        chk("rst_pc_en", 16'(pc_en), 16'h1);
        chk("rst_ifid_en", 16'(ifid_en), 16'h1);
        chk("rst_fwd_a", 16'(fwd_a), 16'h0);
        chk("rst_fwd_b", 16'(fwd_b), 16'h0);
        chk("rst_bubble", 16'(ex_bubble), 16'h0);
        chk("rst_flush", 16'(flush_ifid), 16'h0);
        chk("rst_flags", 16'(flags_out), 16'h0);
        chk("rst_stall_cnt", stall_count, 16'h0);
        tick();

        // ADDS X1 = X2 + X3
        drive(1, 2, 1, 3, 1, 1, 1, 0, 1, 0, 0, 0, 4'b0000); settle();
        chk("adds_fwd_a", 16'(fwd_a), 16'h0);
        tick();
        // SUBS X4 = X1 - X1 (ADDS in EX producing flags 0100)
        drive(1, 1, 1, 1, 1, 4, 1, 0, 1, 0, 0, 0, 4'b0100); settle();
        chk("subs_fwd_a_ex", 16'(fwd_a), 16'h1);
        chk("subs_fwd_b_ex", 16'(fwd_b), 16'h1);
        chk("subs_no_stall", 16'(pc_en), 16'h1);
        tick();
        // ADD X6 = X1 + X7 (SUBS in EX producing flags 0010)
        drive(1, 1, 1, 7, 1, 6, 1, 0, 0, 0, 0, 0, 4'b0010); settle();
        chk("add_fwd_a_mem", 16'(fwd_a), 16'h2);
        chk("add_fwd_b_rf", 16'(fwd_b), 16'h0);
        tick();
        // X8 = X1 op X4: X1 in WB, X4 in MEM; EX not flag-setting so 1111 is ignored
        drive(1, 1, 1, 4, 1, 8, 1, 0, 0, 0, 0, 0, 4'b1111); settle();
        chk("d_fwd_a_wb", 16'(fwd_a), 16'h3);
        chk("d_fwd_b_mem", 16'(fwd_b), 16'h2);
        chk("d_flags_reg", 16'(flags_out), 16'h2);
        tick();
        // X8 = X6 op X8: X6 in MEM, X8 in EX
        drive(1, 6, 1, 8, 1, 8, 1, 0, 0, 0, 0, 0, 4'b0000); settle();
        chk("e_fwd_a_mem", 16'(fwd_a), 16'h2);
        chk("e_fwd_b_ex", 16'(fwd_b), 16'h1);
        chk("e_flags_kept", 16'(flags_out), 16'h2);
        tick();
        // X8 in both EX and MEM: nearest wins; X6 now in WB
        drive(1, 8, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000); settle();
        chk("f_fwd_a_prio", 16'(fwd_a), 16'h1);
        chk("f_fwd_b_wb", 16'(fwd_b), 16'h3);
        tick();
        // Rn not used -> no forward even though X8 is in MEM
        drive(1, 8, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000); settle();
        chk("g_fwd_a_unused", 16'(fwd_a), 16'h0);
        chk("g_fwd_b_mem", 16'(fwd_b), 16'h2);
        tick();

        // LDUR X5 then ADDI X10 = X5 + imm
        drive(1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 4'b0000); settle();
        chk("ldur_no_stall", 16'(pc_en), 16'h1);
        tick();
        drive(1, 5, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0, 4'b0000); settle();
        chk("lu_pc_en", 16'(pc_en), 16'h0);
        chk("lu_ifid_en", 16'(ifid_en), 16'h0);
        chk("lu_bubble", 16'(ex_bubble), 16'h1);
        chk("lu_fwd_a", 16'(fwd_a), 16'h0);
        tick();
        settle();
        chk("lu2_pc_en", 16'(pc_en), 16'h1);
        chk("lu2_bubble", 16'(ex_bubble), 16'h0);
        chk("lu2_fwd_a_mem", 16'(fwd_a), 16'h2);
        chk("lu2_stall_cnt", stall_count, 16'h1);
        tick();

        // Load into XZR, then read X31 on both operands
        drive(1, 0, 0, 0, 0, 31, 1, 1, 0, 0, 0, 0, 4'b0000); settle();
        tick();
        drive(1, 31, 1, 31, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000); settle();
        chk("xzr_fwd_a", 16'(fwd_a), 16'h0);
        chk("xzr_fwd_b", 16'(fwd_b), 16'h0);
        chk("xzr_no_stall", 16'(pc_en), 16'h1);
        chk("xzr_no_bubble", 16'(ex_bubble), 16'h0);
        tick();

        // SUBS X12 = X10 - X13 (X10 in WB)
        drive(1, 10, 1, 13, 1, 12, 1, 0, 1, 0, 0, 0, 4'b0000); settle();
        chk("subs2_fwd_a_wb", 16'(fwd_a), 16'h3);
        chk("subs2_flags_reg", 16'(flags_out), 16'h2);
        tick();
        // B.LT taken with SUBS in EX producing 1000
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4'b1000); settle();
        chk("blt_flags_fwd", 16'(flags_out), 16'h8);
        chk("blt_flush_now", 16'(flush_ifid), 16'h0);
        chk("blt_pc_en", 16'(pc_en), 16'h1);
        tick();
        // Instruction behind the branch (writes X14); EX is the non-flag B.LT
        drive(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 1, 4'b0001); settle();
        chk("blt_flush_next", 16'(flush_ifid), 16'h1);
        chk("blt_flags_reg", 16'(flags_out), 16'h8);
        tick();
        // Squashed X14 must not forward; X12 in WB does
        drive(1, 14, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000); settle();
        chk("blt_flush_one", 16'(flush_ifid), 16'h0);
        chk("squash_fwd_a", 16'(fwd_a), 16'h0);
        chk("squash_fwd_b", 16'(fwd_b), 16'h3);
        tick();

        // LDUR X9 then CBZ X9 taken
        drive(1, 2, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 4'b0000); settle();
        tick();
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 1, 1, 0, 4'b0000); settle();
        chk("cbz_stall", 16'(pc_en), 16'h0);
        chk("cbz_bubble", 16'(ex_bubble), 16'h1);
        chk("cbz_no_flush", 16'(flush_ifid), 16'h0);
        tick();
        settle();
        chk("cbz2_pc_en", 16'(pc_en), 16'h1);
        chk("cbz2_fwd_b_mem", 16'(fwd_b), 16'h2);
        chk("cbz2_flush_wait", 16'(flush_ifid), 16'h0);
        chk("cbz2_stall_cnt", stall_count, 16'h2);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000); settle();
        chk("cbz_flush", 16'(flush_ifid), 16'h1);
        tick();
        idle(); settle();
        chk("cbz_flush_end", 16'(flush_ifid), 16'h0);
        tick();

        // Same pair again, with reset asserted during the stall
        drive(1, 2, 1, 0, 0, 9, 1, 1, 0, 0, 0, 0, 4'b0000); settle();
        tick();
        drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 1, 1, 0, 4'b0000); settle();
        chk("rcbz_stall", 16'(pc_en), 16'h0);
        reset = 1'b1;
        #1;
        chk("rcbz_pc_en", 16'(pc_en), 16'h1);
        chk("rcbz_bubble", 16'(ex_bubble), 16'h0);
        chk("rcbz_stall_cnt", stall_count, 16'h0);
        tick();
        idle();
        settle();
        reset = 1'b0;
        chk("rcbz_no_flush", 16'(flush_ifid), 16'h0);
        tick();
        settle();
        chk("rcbz_no_flush2", 16'(flush_ifid), 16'h0);
        chk("rcbz_pc_en2", 16'(pc_en), 16'h1);
        chk("rcbz_flags_clr", 16'(flags_out), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline hazard controller for the 5-stage LEGv8 core (IF/ID/EX/MEM/WB). It sits beside the decode stage and keeps its own shadow record of the destination register, write-enable and load status for each in-flight instruction in EX, MEM and WB.
- It drives three kinds of control:
  - forwarding selects for both ID operands;
  - load-use stalls (PC/IF-ID hold plus an EX bubble);
  - IF/ID flush on taken branches.
- It also owns the architectural flag register written by ADDS/SUBS and selects forwarded flags for B.LT.

Parameters:
- REG_W, 5, register index width.
- ZERO_REG, 31, index of XZR. Never forwarded and never a hazard source.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  ID stage holds a real instruction (0 = bubble).
- id_rn  in  REG_W  first source register.
- id_rm  in  REG_W  second source register (already muxed by Reg2Loc).
- id_uses_rn  in  1  instruction reads Rn.
- id_uses_rm  in  1  instruction reads Rm / Rt.
- id_rd  in  REG_W  destination register (X30 for BL).
- id_regwrite  in  1  decoded RegWrite.
- id_read_en  in  1  decoded read_en (load).
- id_flagset  in  1  decoded flagSet.
- id_was_branch  in  1  decoded wasBranch.
- id_br_taken  in  1  branch resolved taken in ID (BrTaken / BRSignal).
- id_is_blt  in  1  instruction is B.LT (consumes flags).
- ex_flags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- fwd_a  out  2  Rn source select: 00 register file, 01 EX result, 10 MEM result, 11 WB result.
- fwd_b  out  2  Rm source select; same encoding as fwd_a.
- flags_out  out  4  flags for B.LT evaluation in ID; registered flags or forwarded ex_flags.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- ex_bubble  out  1  force EX-stage control to NOP this cycle.
- flush_ifid  out  1  zero the IF/ID register at the next edge.
- stall_count  out  16  saturating count of stall cycles (performance counter).

Behaviour:
- Shadow pipeline: three entries EX, MEM and WB, each holding {valid, rd, regwrite, is_load, flagset}.
  - Every edge, MEM moves to WB and EX moves to MEM.
  - EX loads the ID fields with valid = id_valid & ~ex_bubble & ~flush_ifid_q. A stalled or flushed instruction therefore never enters the shadow pipeline.
- Hazard match for stage S and source r: S.valid & S.regwrite & S.rd == r & r != ZERO_REG & uses_r.
- Forwarding priority: EX first (01), then MEM (10), then WB (11), then 00. The nearest producer always wins.
  - The EX match is suppressed when EX.is_load; the load-use stall handles that case.
- Load-use stall: asserted combinationally when id_valid & EX.valid & EX.is_load and EX.rd matches a used source.
  - While stalled: pc_en=0, ifid_en=0, ex_bubble=1.
  - A stall lasts exactly 1 cycle. Next cycle the load is in MEM and forwarding uses 10.
- Branch flush:
  - If id_valid & id_was_branch & id_br_taken and no stall this cycle, set flush_ifid_q, which is registered. flush_ifid = flush_ifid_q.
  - The instruction fetched behind the branch is squashed the following cycle.
  - Stall takes priority over flush: a branch waiting on a load is evaluated again after the stall.
- Flags:
  - flags_q updates from ex_flags at the edge when EX.valid & EX.flagset.
  - flags_out = ex_flags when id_is_blt & EX.valid & EX.flagset; otherwise flags_out = flags_q.
- stall_count increments once per stall cycle and saturates at 16'hFFFF.
- Reset values:
  - All shadow valids 0, flags_q 0, flush_ifid_q 0, stall_count 0.
  - Resulting outputs: fwd_a = fwd_b = 00, pc_en = 1, ifid_en = 1, ex_bubble = 0, flush_ifid = 0, flags_out = 0.
- Reset mid-operation clears in-flight hazards immediately (asynchronous). No stall or flush survives reset.
- Simultaneous hazards: a match on both Rn and Rm still produces a single 1-cycle stall. Independent per-operand forwarding is allowed (e.g. fwd_a=01, fwd_b=10).
- id_valid=0: no stall and no flush. Forward selects are still computed and are don't-care.

Test Plan:
- Reset, then idle with id_valid=0 -> pc_en=1, ifid_en=1, fwd_a=fwd_b=00, stall_count=0.
- ADDS X1 = X2 + X3, then SUBS X4 = X1 - X1 -> fwd_a=01, fwd_b=01, no stall. A third instruction reading X1 -> fwd=10.
- LDUR X5 in EX, ADDI reading X5 in ID -> exactly 1 cycle of pc_en=0, ifid_en=0, ex_bubble=1. Next cycle fwd_a=10. stall_count=1.
- Write to X31 in EX while ID reads X31 -> fwd_a=00 and no stall.
- SUBS in EX with ex_flags=4'b1000, B.LT in ID -> flags_out=4'b1000 that cycle. With id_br_taken=1, flush_ifid=1 on the next cycle only.
- LDUR X9 followed by CBZ X9 taken -> stall first, then flush asserted one cycle after the CBZ resolves. Asserting reset during the stall -> pc_en=1 and no flush afterwards.
